// File: rtl/vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : vx_issue_scoreboard
// Brief    : Per-warp register hazard gate between ibuffer and demux, with
//            writeback-driven clears and a sticky stall watchdog.
//            Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback
//            clear unblock a dependent instruction.
// Revision : 1.0 - initial release
// ============================================================================
module vx_issue_scoreboard #(
    parameter  int NUM_WARPS   = 4,
    parameter  int NUM_REGS    = 64,
    parameter  int STALL_LIMIT = 65535,
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NR_BITS     = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NW_BITS-1:0] in_wid,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic               in_wb,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [NR_BITS-1:0] in_rs3,
    input  logic [2:0]         in_used_rs,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               wb_valid,
    input  logic [NW_BITS-1:0] wb_wid,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,
    output logic               stall_timeout,
    output logic [NW_BITS-1:0] stall_wid
);

    localparam int                  C_CNT_BITS = $clog2(STALL_LIMIT + 1);
    localparam logic [C_CNT_BITS-1:0] C_LIMIT  = C_CNT_BITS'(STALL_LIMIT);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] w_pend_view;
    logic [C_CNT_BITS-1:0]              stall_cnt_q, stall_cnt_d;
    logic                               stall_timeout_q, stall_timeout_d;
    logic [NW_BITS-1:0]                 stall_wid_q, stall_wid_d;
    logic                               w_hazard;
    logic                               w_fire;
    logic                               w_wb_clr;

    assign w_wb_clr = wb_valid & wb_eop;

    // Pending view used for the hazard check; bypass folds in this cycle's clear.
    always_comb begin
        w_pend_view = pending_q;
`ifdef SCOREBOARD_BYPASS_EN
        if (w_wb_clr) begin
            w_pend_view[wb_wid][wb_rd] = 1'b0;
        end
`endif
    end

    always_comb begin
        w_hazard = (in_used_rs[0] & w_pend_view[in_wid][in_rs1])
                 | (in_used_rs[1] & w_pend_view[in_wid][in_rs2])
                 | (in_used_rs[2] & w_pend_view[in_wid][in_rs3])
                 | (in_wb         & w_pend_view[in_wid][in_rd]);
    end

    assign out_valid     = in_valid & ~w_hazard;
    assign in_ready      = out_ready & ~w_hazard;
    assign w_fire        = in_valid & in_ready;
    assign stall_timeout = stall_timeout_q;
    assign stall_wid     = stall_wid_q;

    // Clear first, then set, so a same-cycle set of the same bit wins.
    always_comb begin
        pending_d = pending_q;
        if (w_wb_clr) begin
            pending_d[wb_wid][wb_rd] = 1'b0;
        end
        if (w_fire && in_wb) begin
            pending_d[in_wid][in_rd] = 1'b1;
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_d[w][0] = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d     = '0;
        stall_timeout_d = stall_timeout_q;
        stall_wid_d     = stall_wid_q;
        if (in_valid && w_hazard) begin
            stall_cnt_d = (stall_cnt_q == C_LIMIT) ? stall_cnt_q
                                                   : stall_cnt_q + C_CNT_BITS'(1);
        end
        if ((stall_cnt_d == C_LIMIT) && !stall_timeout_q) begin
            stall_timeout_d = 1'b1;
            stall_wid_d     = in_wid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q       <= '0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
            stall_wid_q     <= '0;
        end else begin
            pending_q       <= pending_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
            stall_wid_q     <= stall_wid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_issue_scoreboard
// Brief    : Directed self-checking bench for vx_issue_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_issue_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
    localparam logic C_BYP = 1'b1;
`else
    localparam logic C_BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_wb, out_valid, out_ready;
    logic [1:0] in_wid, wb_wid, stall_wid;
    logic [5:0] in_rd, in_rs1, in_rs2, in_rs3, wb_rd;
    logic [2:0] in_used_rs;
    logic       wb_valid, wb_eop, stall_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_issue_scoreboard #(
        .NUM_WARPS   (4),
        .NUM_REGS    (64),
        .STALL_LIMIT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wid        (in_wid),
        .in_rd         (in_rd),
        .in_wb         (in_wb),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rs3        (in_rs3),
        .in_used_rs    (in_used_rs),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .wb_valid      (wb_valid),
        .wb_wid        (wb_wid),
        .wb_rd         (wb_rd),
        .wb_eop        (wb_eop),
        .stall_timeout (stall_timeout),
        .stall_wid     (stall_wid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] w, input logic [5:0] rd,
                         input logic wb, input logic [5:0] rs1, input logic [5:0] rs2,
                         input logic [2:0] used);
        in_valid   = v;
        in_wid     = w;
        in_rd      = rd;
        in_wb      = wb;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rs3     = 6'd0;
        in_used_rs = used;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_wid    = 2'd0;
        wb_rd     = 6'd0;
        wb_eop    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        tick();

        // Reset state
        drive(1, 0, 0, 0, 0, 0, 3'b000);
        chk("reset_out_valid", out_valid, 1);
        chk("reset_timeout", stall_timeout, 0);
        chk("reset_stall_wid", stall_wid, 0);
        reset = 1'b1;
        tick();

        // RAW on w0 r7
        drive(1, 0, 7, 1, 0, 0, 3'b000);
        chk("raw_issue_valid", out_valid, 1);
        chk("raw_issue_ready", in_ready, 1);
        tick();
        drive(1, 0, 0, 0, 7, 0, 3'b001);
        chk("raw_block_valid", out_valid, 0);
        chk("raw_block_ready", in_ready, 0);
        tick();
        chk("raw_hold_valid", out_valid, 0);

        // Non-eop writeback beat leaves the bit pending
        wb_valid = 1'b1; wb_wid = 2'd0; wb_rd = 6'd7; wb_eop = 1'b0;
        #1;
        chk("noneop_cycle_valid", out_valid, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("noneop_after_valid", out_valid, 0);

        // Eop writeback releases the dependent (same cycle only with bypass)
        wb_valid = 1'b1; wb_eop = 1'b1;
        #1;
        chk("eop_cycle_valid", out_valid, C_BYP);
        tick();
        wb_valid = 1'b0; wb_eop = 1'b0;
        #1;
        chk("eop_after_valid", out_valid, 1);
        tick();

        // Per-warp isolation, WAW, unused sources, register 0
        drive(1, 2, 3, 1, 0, 0, 3'b000);
        chk("w2_issue_valid", out_valid, 1);
        tick();
        drive(1, 1, 0, 0, 3, 0, 3'b001);
        chk("iso_w1_valid", out_valid, 1);
        drive(1, 2, 0, 0, 0, 3, 3'b010);
        chk("w2_rs2_valid", out_valid, 0);
        drive(1, 2, 3, 1, 0, 0, 3'b000);
        chk("w2_waw_valid", out_valid, 0);
        drive(1, 2, 3, 0, 3, 0, 3'b000);
        chk("unused_rs_valid", out_valid, 1);
        drive(1, 2, 0, 1, 0, 0, 3'b000);
        chk("rd0_issue_valid", out_valid, 1);
        tick();
        drive(1, 2, 0, 0, 0, 0, 3'b001);
        chk("rd0_source_valid", out_valid, 1);

        // Backpressure: no fire means no pending set
        out_ready = 1'b0;
        drive(1, 1, 9, 1, 0, 0, 3'b000);
        chk("bp_valid", out_valid, 1);
        chk("bp_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        drive(1, 1, 0, 0, 9, 0, 3'b001);
        chk("bp_noset_valid", out_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 3'b000);
        tick();

        // Watchdog: w3 blocked for STALL_LIMIT cycles
        drive(1, 3, 10, 1, 0, 0, 3'b000);
        tick();
        drive(1, 3, 0, 0, 10, 0, 3'b001);
        chk("wd_blocked_valid", out_valid, 0);
        repeat (7) tick();
        chk("wd_before_limit", stall_timeout, 0);
        tick();
        chk("wd_timeout", stall_timeout, 1);
        chk("wd_wid", stall_wid, 3);
        drive(1, 2, 0, 0, 0, 3, 3'b010);
        tick();
        tick();
        chk("wd_wid_first_only", stall_wid, 3);
        wb_valid = 1'b1; wb_wid = 2'd3; wb_rd = 6'd10; wb_eop = 1'b1;
        tick();
        wb_valid = 1'b0; wb_eop = 1'b0;
        drive(1, 3, 0, 0, 10, 0, 3'b001);
        chk("wd_cleared_valid", out_valid, 1);
        chk("wd_sticky", stall_timeout, 1);

        // Asynchronous reset mid-stream with w1 r5 pending
        drive(1, 1, 5, 1, 0, 0, 3'b000);
        tick();
        drive(1, 1, 0, 0, 5, 0, 3'b001);
        chk("ar_pre_valid", out_valid, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1);
        chk("ar_timeout", stall_timeout, 0);
        chk("ar_stall_wid", stall_wid, 0);
        drive(1, 2, 0, 0, 0, 3, 3'b010);
        chk("ar_w2_cleared", out_valid, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_after_valid", out_valid, 1);
        chk("ar_after_timeout", stall_timeout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
